// File: rtl/ysyx_24070017_regfile_mp_pkg.sv
// Shared constants for the multi-port register file.
// Holds the default word length and register count that used to be global
// defines, plus the helper that turns a register count into an address width.
package ysyx_24070017_regfile_mp_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  // Address width for a power-of-2 register count. A one-entry file still
  // gets one address bit, so no vector ends up zero-width.
  function automatic int aw_of(input int nreg);
    return (nreg <= 1) ? 1 : $clog2(nreg);
  endfunction

endpackage

// File: rtl/ysyx_24070017_regfile_mp_if.sv
// Decode/writeback bundle for the register file.
//   master : the pipeline. It drives the read addresses, the write ports,
//            alloc and flush, and it samples rdata, rbusy and busy_vec.
//   slave  : the register file.
// Read port k uses raddr[k*AW +: AW] and rdata[k*XLEN +: XLEN]. Write ports
// are packed the same way.
interface ysyx_24070017_regfile_mp_if #(
  parameter int XLEN = ysyx_24070017_regfile_mp_pkg::XLEN_DEF,
  parameter int NREG = ysyx_24070017_regfile_mp_pkg::NREG_DEF,
  parameter int NRD  = 2,
  parameter int NWR  = 1,
  localparam int AW  = ysyx_24070017_regfile_mp_pkg::aw_of(NREG)
);
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic [NWR-1:0]      wen;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic                flush;
  logic [NREG-1:0]     busy_vec;

  modport master (output raddr, wen, waddr, wdata, alloc_en, alloc_addr, flush,
                  input  rdata, rbusy, busy_vec);
  modport slave  (input  raddr, wen, waddr, wdata, alloc_en, alloc_addr, flush,
                  output rdata, rbusy, busy_vec);
endinterface

// File: rtl/ysyx_24070017_rf_scoreboard.sv
// Per-register busy scoreboard. It tracks which registers have an in-flight
// writeback.
//   clk, rst     : clock and async active-high reset
//   raddr_i      : read addresses, used for the rbusy lookup
//   fwd_hit_i    : read port k is being served by a same-cycle write
//   wen_i/waddr_i: writeback ports, which retire producers
//   alloc_en_i/alloc_addr_i : decode allocates a new producer
//   flush_i      : clear every busy bit
//   rbusy_o      : per-read-port busy flag
//   busy_vec_o   : raw busy state
// Next-state priority per register is: flush, then alloc, then write, then hold.
module ysyx_24070017_rf_scoreboard
  import ysyx_24070017_regfile_mp_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int NWR  = 1,
  localparam int AW  = aw_of(NREG)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRD-1:0][AW-1:0]  raddr_i,
  input  logic [NRD-1:0]          fwd_hit_i,
  input  logic [NWR-1:0]          wen_i,
  input  logic [NWR-1:0][AW-1:0]  waddr_i,
  input  logic                    alloc_en_i,
  input  logic [AW-1:0]           alloc_addr_i,
  input  logic                    flush_i,
  output logic [NRD-1:0]          rbusy_o,
  output logic [NREG-1:0]         busy_vec_o
);
  logic [NREG-1:0] busy_q, busy_d, clr;

  always_comb begin
    clr = '0;
    for (int j = 0; j < NWR; j++)
      if (wen_i[j]) clr[waddr_i[j]] = 1'b1;
    busy_d = busy_q;
    for (int i = 1; i < NREG; i++) begin
      if (flush_i)                                    busy_d[i] = 1'b0;
      else if (alloc_en_i && alloc_addr_i == AW'(i))  busy_d[i] = 1'b1;
      else if (clr[i])                                busy_d[i] = 1'b0;
    end
    busy_d[0] = 1'b0;  // x0 never has a producer
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;

  // Lookup uses the registered state, so a same-cycle alloc shows up one
  // cycle later. A forwarded write already supplies the value.
  always_comb begin
    rbusy_o = '0;
    for (int k = 0; k < NRD; k++)
      rbusy_o[k] = (raddr_i[k] != '0) && busy_q[raddr_i[k]] && !fwd_hit_i[k];
  end

  assign busy_vec_o = busy_q;
endmodule

// File: rtl/ysyx_24070017_regfile_mp.sv
// Multi-port integer register file with an optional write-to-read bypass
// and a busy scoreboard.
//   clk, rst : clock and async active-high reset
//   bus      : slave side of the decode/writeback bundle
//              (reads, writes, alloc, flush, busy outputs)
// Register 0 is hardwired to zero. On a same-address write collision the
// highest-index write port wins, both in the array and in the bypass mux.
module ysyx_24070017_regfile_mp
  import ysyx_24070017_regfile_mp_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  localparam int AW    = aw_of(NREG)
) (
  input logic                      clk,
  input logic                      rst,
  ysyx_24070017_regfile_mp_if.slave bus
);
  logic [XLEN-1:0]                rf_q [NREG];
  logic [NRD-1:0][AW-1:0]         ra;
  logic [NWR-1:0][AW-1:0]         wa;
  logic [NWR-1:0][XLEN-1:0]       wd;
  logic [NRD-1:0][XLEN-1:0]       rd;
  logic [NRD-1:0]                 hit, fwd_hit;

  assign ra = bus.raddr;
  assign wa = bus.waddr;
  assign wd = bus.wdata;

  // The loop runs in ascending port order, so the last matching port
  // overwrites earlier ones. That makes the highest-index port win.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++)
        if (bus.wen[j] && wa[j] != '0) rf_q[wa[j]] <= wd[j];
    end

  always_comb begin
    rd  = '0;
    hit = '0;
    for (int k = 0; k < NRD; k++) begin
      if (ra[k] != '0) begin
        rd[k] = rf_q[ra[k]];
        for (int j = 0; j < NWR; j++)
          if (bus.wen[j] && wa[j] == ra[k]) begin
            hit[k] = 1'b1;
            if (BYPASS != 0) rd[k] = wd[j];
          end
      end
    end
  end

  // rbusy is only masked when the value is really being forwarded.
  assign fwd_hit   = (BYPASS != 0) ? hit : '0;
  assign bus.rdata = rd;

  ysyx_24070017_rf_scoreboard #(.NREG(NREG), .NRD(NRD), .NWR(NWR)) u_sb (
    .clk          (clk),
    .rst          (rst),
    .raddr_i      (ra),
    .fwd_hit_i    (fwd_hit),
    .wen_i        (bus.wen),
    .waddr_i      (wa),
    .alloc_en_i   (bus.alloc_en),
    .alloc_addr_i (bus.alloc_addr),
    .flush_i      (bus.flush),
    .rbusy_o      (bus.rbusy),
    .busy_vec_o   (bus.busy_vec)
  );
endmodule
